light_sequence_checker: RTL
===========================

Name: light_sequence_checker

Overview:
- Passive observer on the far end of the traffic-light controller's output interface: consumes LightState, TimerExpired and CarDetected; drives nothing back into the controller.
- Enforces the legal light sequence, minimum dwell times and a red-starvation limit.
- Counts completed light cycles and latches the first violation with a code for software/bench readout.
- Sits beside the controller in the integration top and in the controller bench as a live checker.

Parameters:
MIN_GREEN, 3, minimum consecutive sampled cycles in GREEN before leaving it
MIN_YELLOW, 2, minimum consecutive sampled cycles in YELLOW before leaving it
MAX_RED_WAIT, 8, maximum consecutive cycles RED with CarDetected=1 before violation
CNT_W, 8, width of cycle_count
DWELL_W, 8, width of internal dwell/wait counters (saturating)

Ports:
clk  input  1  system clock, rising edge
reset  input  1  synchronous, active-low reset
LightState  input  2  observed light: 2'b00 RED, 2'b01 GREEN, 2'b10 YELLOW, 2'b11 illegal
CarDetected  input  1  car sensor as seen by the controller
TimerExpired  input  1  controller timer flag; observed only, not checked
clear_err  input  1  one-cycle pulse, clears latched error
err  output  1  sticky violation flag
err_code  output  3  code of first violation since reset/clear; 0 = none
cycle_count  output  CNT_W  completed RED->GREEN->YELLOW->RED cycles, saturating
dwell  output  DWELL_W  cycles spent in current observed state, saturating

Behaviour:
- Reset (reset=0 at a rising edge): err=0, err_code=0, cycle_count=0, dwell=0, red_wait=0, armed=0. reset dominates all other inputs.
- First edge after reset released (armed=0):
  - capture LightState as prev_state and set dwell=1, armed=1.
  - No checks; 2'b11 is still flagged as code 4.
- Each edge with armed=1, same state (LightState==prev_state): dwell increments, saturating at all-ones.
- Each edge with armed=1, state change: evaluate the checks below against the old prev_state/dwell, then prev_state<=LightState, dwell<=1.
- Legal transitions: RED->GREEN, GREEN->YELLOW, YELLOW->RED.
- Violation codes:
  - 4: LightState==2'b11 sampled; illegal state is not stored into prev_state.
  - 1: illegal transition, any other change.
  - 2: GREEN->YELLOW with old dwell < MIN_GREEN.
  - 3: YELLOW->RED with old dwell < MIN_YELLOW.
  - 5: red starvation.
- Violation priority when several occur on one edge: 4 > 1 > 2 > 3 > 5.
- red_wait:
  - Increments on each edge where the sampled state is RED and CarDetected=1 (saturating).
  - Clears to 0 when CarDetected=0 or state != RED.
  - Code 5 fires on the edge red_wait goes from MAX_RED_WAIT to MAX_RED_WAIT+1; fires once per wait episode.
- cycle_count increments on every YELLOW->RED transition that is not flagged; holds at 2^CNT_W-1.
- Error latch:
  - On a violation with err=0: err<=1, err_code<=code, on the same edge that samples the offending input.
  - Further violations are ignored while err=1.
  - clear_err=1: err<=0, err_code<=0. If a violation occurs on the same edge, the new violation is captured instead (violation wins).
- Checking and counting continue while err=1.
- All outputs registered; no combinational input->output paths. Latency is one edge from sample to output.
- Reset asserted mid-cycle or mid-error clears everything. The next released edge re-arms without checks.

Test Plan:
- Reset held 2 cycles, then RED 2 cycles, GREEN 4, YELLOW 3, RED 1 (CarDetected=0) -> err=0, cycle_count=1, dwell=1 after final RED edge.
- RED then GREEN for only 2 cycles, then YELLOW (MIN_GREEN=3) -> err=1, err_code=2 on the YELLOW-sampling edge; cycle_count still increments at the later legal YELLOW->RED only if MIN_YELLOW met.
- GREEN directly to RED -> err_code=1; then LightState=2'b11 -> err_code stays 1 (first error held).
- RED with CarDetected=1 for 9 consecutive edges -> err=1, err_code=5 on the 9th edge; clear_err pulse then 10 more edges -> no re-fire.
- clear_err pulsed on the same edge LightState=2'b11 is sampled -> err=1, err_code=4.
- 256 legal cycles with CNT_W=8 -> cycle_count=255 (saturated); reset mid-GREEN -> all outputs 0 next cycle, first post-reset sample of YELLOW raises no error.

Source files
------------

// File: rtl/light_sequence_checker.sv
// Passive checker for the traffic-light controller output: legal sequence, dwell minima and red starvation.
// One edge from sample to registered outputs; the first violation is latched until clear_err or reset.
module light_sequence_checker #(
  parameter int MIN_GREEN    = 3,
  parameter int MIN_YELLOW   = 2,
  parameter int MAX_RED_WAIT = 8,
  parameter int CNT_W        = 8,
  parameter int DWELL_W      = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [1:0]         LightState,
  input  logic               CarDetected,
  input  logic               TimerExpired,
  input  logic               clear_err,
  output logic               err,
  output logic [2:0]         err_code,
  output logic [CNT_W-1:0]   cycle_count,
  output logic [DWELL_W-1:0] dwell
);

  typedef enum logic [1:0] {
    RED    = 2'b00,
    GREEN  = 2'b01,
    YELLOW = 2'b10,
    BAD    = 2'b11
  } light_t;

  typedef enum logic [2:0] {
    C_NONE   = 3'd0,
    C_TRANS  = 3'd1,
    C_GREEN  = 3'd2,
    C_YELLOW = 3'd3,
    C_BAD    = 3'd4,
    C_STARVE = 3'd5
  } code_t;

  localparam logic [DWELL_W-1:0] MIN_G   = DWELL_W'(MIN_GREEN);
  localparam logic [DWELL_W-1:0] MIN_Y   = DWELL_W'(MIN_YELLOW);
  localparam logic [DWELL_W-1:0] RED_LIM = DWELL_W'(MAX_RED_WAIT);

  light_t             cur;
  light_t             prev_state;
  logic               armed;
  logic [DWELL_W-1:0] red_wait;

  logic  changed;
  logic  legal;
  logic  red_hold;
  logic  starve;
  logic  cycle_done;
  code_t code;

  // The controller timer is visible on the bus but carries nothing this checker judges.
  logic unused_timer;
  assign unused_timer = TimerExpired;

  assign cur = light_t'(LightState);

  always_comb begin
    changed    = armed && (cur != BAD) && (cur != prev_state);
    legal      = ((prev_state == RED)    && (cur == GREEN))  ||
                 ((prev_state == GREEN)  && (cur == YELLOW)) ||
                 ((prev_state == YELLOW) && (cur == RED));
    red_hold   = (cur == RED) && CarDetected;
    // Fires only on the MAX -> MAX+1 step, so each wait episode reports once.
    starve     = armed && red_hold && (red_wait == RED_LIM);

    code = C_NONE;
    if (cur == BAD)
      code = C_BAD;
    else if (changed && !legal)
      code = C_TRANS;
    else if (changed && (prev_state == GREEN) && (dwell < MIN_G))
      code = C_GREEN;
    else if (changed && (prev_state == YELLOW) && (dwell < MIN_Y))
      code = C_YELLOW;
    else if (starve)
      code = C_STARVE;

    cycle_done = changed && (prev_state == YELLOW) && (cur == RED) && (code == C_NONE);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      armed       <= 1'b0;
      prev_state  <= RED;
      dwell       <= '0;
      red_wait    <= '0;
      cycle_count <= '0;
      err         <= 1'b0;
      err_code    <= 3'd0;
    end else begin
      if (red_hold) begin
        if (red_wait != '1)
          red_wait <= red_wait + 1'b1;
      end else begin
        red_wait <= '0;
      end

      // An illegal encoding never becomes the reference state; dwell simply holds.
      if (cur != BAD) begin
        if (!armed || changed) begin
          armed      <= 1'b1;
          prev_state <= cur;
          dwell      <= DWELL_W'(1);
        end else if (dwell != '1) begin
          dwell <= dwell + 1'b1;
        end
      end

      if (cycle_done && (cycle_count != '1))
        cycle_count <= cycle_count + 1'b1;

      if ((code != C_NONE) && (!err || clear_err)) begin
        err      <= 1'b1;
        err_code <= code;
      end else if (clear_err) begin
        err      <= 1'b0;
        err_code <= 3'd0;
      end
    end
  end

endmodule
